// File: rtl/keypad_emu_pkg.sv
// Shared types for the keypad emulator: FSM states, key-to-matrix mapping, idle column level.
// Bounce states exist only when KEYPAD_EMU_BOUNCE_EN is defined.
package keypad_emu_pkg;

  localparam logic [3:0] KEYPAD_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
`ifdef KEYPAD_EMU_BOUNCE_EN
    ST_BOUNCE_IN  = 3'd1,
`endif
    ST_HOLD       = 3'd2,
`ifdef KEYPAD_EMU_BOUNCE_EN
    ST_BOUNCE_OUT = 3'd3,
`endif
    ST_GAP        = 3'd4
  } state_e;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
  } rc_t;

  function automatic rc_t key_to_rc(input logic [3:0] key);
    rc_t m;
    m = '0;
    case (key)
      4'hA: m = {2'd0, 2'd3};
      4'hB: m = {2'd0, 2'd2};
      4'hC: m = {2'd0, 2'd1};
      4'hD: m = {2'd0, 2'd0};
      4'h1: m = {2'd1, 2'd3};
      4'h3: m = {2'd1, 2'd2};
      4'h5: m = {2'd1, 2'd1};
      4'h7: m = {2'd1, 2'd0};
      4'h2: m = {2'd2, 2'd3};
      4'h4: m = {2'd2, 2'd2};
      4'h6: m = {2'd2, 2'd1};
      4'h8: m = {2'd2, 2'd0};
      4'h9: m = {2'd3, 2'd3};
      4'h0: m = {2'd3, 2'd2};
      4'hE: m = {2'd3, 2'd1};
      default: m = {2'd3, 2'd0};  // 4'hF
    endcase
    return m;
  endfunction

  // A zero-length segment still lasts one cycle.
  function automatic int eff_cycles(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/keypad_emu_if.sv
// Key request handshake: key_valid/key_code accepted when key_valid && key_ready on a rising
// clk edge; key_done is a one-cycle completion pulse from the emulator.
interface keypad_emu_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       key_done;

  modport master (output key_valid, output key_code, input key_ready, input key_done);
  modport slave  (input key_valid, input key_code, output key_ready, output key_done);
endinterface

// File: rtl/keypad_emu_contact.sv
// Segment timer and contact register; the FSM starts each segment and marks the press busy.
// KEYPAD_EMU_BOUNCE_EN adds the bounce toggle counter.
module keypad_emu_contact
  import keypad_emu_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4800,
  parameter int GAP_CYCLES     = 2400,
  parameter int BOUNCE_CYCLES  = 48,
  parameter int BOUNCE_TOGGLES = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start_i,
  input  logic   busy_i,
  input  state_e seg_i,
  input  state_e start_seg_i,
  output logic   seg_done_o,
  output logic   contact_o
);

  localparam int HOLD_E = eff_cycles(HOLD_CYCLES);
  localparam int GAP_E  = eff_cycles(GAP_CYCLES);
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BNC_E  = eff_cycles(BOUNCE_CYCLES);
  localparam int MAXHG  = (HOLD_E > GAP_E) ? HOLD_E : GAP_E;
  localparam int MAXP   = (MAXHG > BNC_E) ? MAXHG : BNC_E;
  localparam int TW     = $clog2(BOUNCE_TOGGLES + 1);
`else
  localparam int MAXP   = (HOLD_E > GAP_E) ? HOLD_E : GAP_E;
`endif
  localparam int CW     = $clog2(MAXP + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          closed_q, closed_d;
  logic          start_closed;

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [TW-1:0] tog_q, tog_d;
  logic          bnc_wrap;
  logic          in_bounce;

  assign bnc_wrap     = (cnt_q == CW'(BNC_E - 1));
  assign in_bounce    = (seg_i == ST_BOUNCE_IN) || (seg_i == ST_BOUNCE_OUT);
  assign start_closed = (start_seg_i == ST_BOUNCE_IN) || (start_seg_i == ST_HOLD);
`else
  logic unused_bounce_cfg;
  assign unused_bounce_cfg = (BOUNCE_CYCLES + BOUNCE_TOGGLES) != 0;
  assign start_closed      = (start_seg_i == ST_HOLD);
`endif

  always_comb begin
    seg_done_o = 1'b0;
    cnt_d      = cnt_q;
    closed_d   = closed_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
    tog_d      = tog_q;
`endif
    case (seg_i)
      ST_HOLD: seg_done_o = (cnt_q == CW'(HOLD_E - 1));
      ST_GAP:  seg_done_o = (cnt_q == CW'(GAP_E - 1));
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE_IN, ST_BOUNCE_OUT: seg_done_o = bnc_wrap && (tog_q == TW'(BOUNCE_TOGGLES - 1));
`endif
      default: seg_done_o = 1'b0;
    endcase

    // Segment entry sets the contact level; the final bounce toggle coincides with that entry.
    if (start_i) begin
      cnt_d    = '0;
      closed_d = start_closed;
`ifdef KEYPAD_EMU_BOUNCE_EN
      tog_d    = '0;
`endif
    end else if (!busy_i) begin
      cnt_d    = '0;
      closed_d = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      tog_d    = '0;
    end else if (in_bounce) begin
      if (bnc_wrap) begin
        cnt_d    = '0;
        tog_d    = tog_q + TW'(1);
        closed_d = ~closed_q;
      end else begin
        cnt_d    = cnt_q + CW'(1);
      end
`endif
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      closed_q <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      tog_q    <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      closed_q <= closed_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
      tog_q    <= tog_d;
`endif
    end
  end

  assign contact_o = closed_q;

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator top: key latch, press-sequence FSM and combinational row/col matrix.
// Define KEYPAD_EMU_BOUNCE_EN to emulate contact bounce around the hold.
module keypad_emulator
  import keypad_emu_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4800,
  parameter int GAP_CYCLES     = 2400,
  parameter int BOUNCE_CYCLES  = 48,
  parameter int BOUNCE_TOGGLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  keypad_emu_if.slave kif,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output state_e      dbg_state_o
);

  state_e     state_q, state_d;
  logic [3:0] key_q, key_d;
  logic       done_q, done_d;
  logic       start;
  logic       busy;
  logic       accept;
  logic       seg_done;
  logic       contact;
  rc_t        rc;

  assign kif.key_ready = (state_q == ST_IDLE);
  assign kif.key_done  = done_q;
  assign accept        = kif.key_valid && (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    done_d  = 1'b0;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        key_d   = kif.key_code;
        start   = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
        state_d = ST_BOUNCE_IN;
`else
        state_d = ST_HOLD;
`endif
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE_IN: if (seg_done) begin
        start   = 1'b1;
        state_d = ST_HOLD;
      end
`endif
      ST_HOLD: if (seg_done) begin
        start   = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
        state_d = ST_BOUNCE_OUT;
`else
        state_d = ST_GAP;
`endif
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE_OUT: if (seg_done) begin
        start   = 1'b1;
        state_d = ST_GAP;
      end
`endif
      ST_GAP: if (seg_done) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  keypad_emu_contact #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES),
    .BOUNCE_CYCLES (BOUNCE_CYCLES),
    .BOUNCE_TOGGLES(BOUNCE_TOGGLES)
  ) u_contact (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .busy_i     (busy),
    .seg_i      (state_q),
    .start_seg_i(state_d),
    .seg_done_o (seg_done),
    .contact_o  (contact)
  );

  assign rc = key_to_rc(key_q);

  // Only the latched key's row matters; other rows being driven low never pull a column.
  always_comb begin
    col = KEYPAD_IDLE;
    if (contact && !row[rc.r]) col[rc.c] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized bench for keypad_emulator: a timeline model of each press predicts col,
// key_ready and key_done every cycle; two instances cover normal and zero-length parameters.
module tb_keypad_emulator;
  import keypad_emu_pkg::*;

  localparam int H0 = 20;
  localparam int G0 = 10;
  localparam int B0 = 3;
  localparam int T0 = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam bit BOUNCE_ON = 1'b1;
`else
  localparam bit BOUNCE_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] row;
  logic [3:0] col0, col1;
  state_e     st0, st1;

  keypad_emu_if k0 ();
  keypad_emu_if k1 ();

  keypad_emulator #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0), .BOUNCE_CYCLES(B0), .BOUNCE_TOGGLES(T0))
    dut0 (.clk(clk), .reset(reset), .kif(k0), .row(row), .col(col0), .dbg_state_o(st0));

  keypad_emulator #(.HOLD_CYCLES(0), .GAP_CYCLES(0), .BOUNCE_CYCLES(0), .BOUNCE_TOGGLES(2))
    dut1 (.clk(clk), .reset(reset), .kif(k1), .row(row), .col(col1), .dbg_state_o(st1));

  int hp[2] = '{H0, 0};
  int gp[2] = '{G0, 0};
  int bp[2] = '{B0, 0};
  int tp[2] = '{T0, 2};

  // Keypad layout, index = row*4 + column.
  logic [3:0] pos_key [16] = '{4'hD, 4'hC, 4'hB, 4'hA,
                               4'h7, 4'h5, 4'h3, 4'h1,
                               4'h8, 4'h6, 4'h4, 4'h2,
                               4'hF, 4'hE, 4'h0, 4'h9};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic int eff(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic bit model_closed(input int k, input int h, input int b, input int t);
    int bin;
    bin = t * b;
    if (k < bin) return ((k / b) % 2) == 0;
    if (k < bin + h) return 1'b1;
    if (k < 2 * bin + h) return ((k - bin - h) / b) % 2 == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_col(input logic [3:0] key, input bit closed,
                                           input logic [3:0] rw);
    logic [3:0] c;
    c = 4'b1111;
    for (int p = 0; p < 16; p++)
      if (pos_key[p] == key && closed && !rw[p / 4]) c[p % 4] = 1'b0;
    return c;
  endfunction

  function automatic logic [5:0] obs(input int sel);
    if (sel == 1) return {k1.key_ready, k1.key_done, col1};
    return {k0.key_ready, k0.key_done, col0};
  endfunction

  // drivers
  task automatic set_req(input int sel, input logic v, input logic [3:0] code);
    if (sel == 1) begin
      k1.key_valid = v;
      k1.key_code  = code;
    end else begin
      k0.key_valid = v;
      k0.key_code  = code;
    end
  endtask

  // row_mode: 0 random, 1 fixed 4'b1101, 2 walking zero. pester: 0 none, 1 random, 2 key 2 held.
  task automatic press(input int sel, input logic [3:0] key, input int pester, input int row_mode);
    logic [5:0] exp_q[$];
    logic [3:0] row_q[$];
    logic [5:0] cur;
    logic [3:0] rw;
    int h, g, b, t, total, waited;
    h = eff(hp[sel]);
    g = eff(gp[sel]);
    b = eff(bp[sel]);
    t = BOUNCE_ON ? tp[sel] : 0;
    total = 2 * t * b + h + g;
    for (int k = 0; k <= total + 1; k++) begin
      case (row_mode)
        1:       rw = 4'b1101;
        2:       rw = 4'b1111 ^ (4'b0001 << (k % 4));
        default: rw = 4'($urandom_range(0, 15));
      endcase
      row_q.push_back(rw);
      exp_q.push_back({k >= total, k == total, model_col(key, model_closed(k, h, b, t), rw)});
    end
    @(negedge clk);
    cur = obs(sel);
    waited = 0;
    while (!cur[5] && waited < 200) begin
      @(negedge clk);
      cur = obs(sel);
      waited++;
    end
    check_eq("ready_before_req", 32'(cur[5]), 32'd1);
    set_req(sel, 1'b1, key);
    row = row_q.pop_front();
    for (int k = 0; k <= total + 1; k++) begin
      @(negedge clk);
      check_eq($sformatf("cyc%0d_key%0h_dut%0d", k, key, sel), 32'(obs(sel)), 32'(exp_q.pop_front()));
      if (row_q.size() > 0) row = row_q.pop_front();
      if (k >= total)       set_req(sel, 1'b0, 4'($urandom_range(0, 15)));
      else if (pester == 2) set_req(sel, 1'b1, 4'h2);
      else if (pester == 1) set_req(sel, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      else                  set_req(sel, 1'b0, 4'($urandom_range(0, 15)));
    end
  endtask

  // abort a press of key F five cycles into the hold
  task automatic abort_in_hold();
    int bin0;
    bit done_seen;
    bit idle_bad;
    bin0 = BOUNCE_ON ? T0 * B0 : 0;
    @(negedge clk);
    row = 4'b0111;
    set_req(0, 1'b1, 4'hF);
    @(negedge clk);
    set_req(0, 1'b0, 4'h0);
    repeat (bin0 + 5) @(negedge clk);
    check_eq("abort_hold_col", 32'(col0), 32'h0000000E);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_col", 32'(col0), 32'h0000000F);
    check_eq("abort_ready", 32'(k0.key_ready), 32'd1);
    check_eq("abort_done", 32'(k0.key_done), 32'd0);
    #1 reset = 1'b0;
    done_seen = 1'b0;
    idle_bad  = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (k0.key_done) done_seen = 1'b1;
      if (col0 !== 4'hF || k0.key_ready !== 1'b1) idle_bad = 1'b1;
    end
    check_eq("abort_no_done", 32'(done_seen), 32'd0);
    check_eq("abort_stays_idle", 32'(idle_bad), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    row = 4'b1101;
    set_req(0, 1'b0, 4'h0);
    set_req(1, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    check_eq("rst_col0", 32'(col0), 32'h0000000F);
    check_eq("rst_col1", 32'(col1), 32'h0000000F);
    check_eq("rst_ready0", 32'(k0.key_ready), 32'd1);
    check_eq("rst_done0", 32'(k0.key_done), 32'd0);
    check_eq("rst_state0", 32'(st0), 32'(ST_IDLE));
    check_eq("rst_state1", 32'(st1), 32'(ST_IDLE));
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("idle_col0", 32'(col0), 32'h0000000F);
    check_eq("idle_ready0", 32'(k0.key_ready), 32'd1);

    // first edge after reset, then the directed patterns
    press(0, 4'h7, 0, 1);
    press(0, 4'h5, 0, 1);
    press(0, 4'hA, 0, 2);
    press(0, 4'h1, 1, 1);
    press(0, 4'hF, 2, 0);
    press(0, 4'h2, 0, 1);
    for (int i = 0; i < 6; i++) press(0, 4'($urandom_range(0, 15)), 1, 0);
    for (int i = 0; i < 5; i++) press(1, 4'($urandom_range(0, 15)), 1, 0);
    abort_in_hold();
    press(0, 4'($urandom_range(0, 15)), 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
- REQ-001: Parameter HOLD_CYCLES, default 4800; clock cycles the contact is held closed steady (100 us at 48 MHz).
- REQ-002: Parameter GAP_CYCLES, default 2400; clock cycles the contact is held open after release, before the next key is accepted.
- REQ-003: Parameter BOUNCE_CYCLES, default 48; clock cycles per bounce segment.
- REQ-004: Parameter BOUNCE_TOGGLES, default 4; contact transitions per bounce burst, even, 2..16.
- REQ-005: Port clk, input, 1; sole clock, 48 MHz.
- REQ-006: Port reset, input, 1; asynchronous, active-high reset.
- REQ-007: Port key_valid, input, 1; key request present.
- REQ-008: Port key_code, input, 4; hex key to press.
- REQ-009: Port key_ready, output, 1; emulator can accept a request.
- REQ-010: Port row, input, 4; active-low row drive from the scanner.
- REQ-011: Port col, output, 4; active-low column sense to the scanner.
- REQ-012: Port key_done, output, 1; one-cycle pulse when a press/release sequence completes.

Function
- REQ-013: A request is accepted on the rising edge of clk when key_valid and key_ready are both high; key_code is latched on that edge.
- REQ-014: States are IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT and GAP; key_ready is high only in IDLE.
- REQ-015: On acceptance, IDLE goes to BOUNCE_IN and the contact closes on the next cycle.
- REQ-016: In BOUNCE_IN, the contact toggles every BOUNCE_CYCLES cycles for BOUNCE_TOGGLES transitions, ends closed, then goes to HOLD.
- REQ-017: In HOLD, the contact stays closed for HOLD_CYCLES cycles, then goes to BOUNCE_OUT.
- REQ-018: In BOUNCE_OUT, the first transition opens the contact; it then toggles as in BOUNCE_IN, ends open, then goes to GAP.
- REQ-019: In GAP, the contact stays open for GAP_CYCLES cycles; on the GAP-to-IDLE transition, key_done pulses high for exactly one cycle.
- REQ-020: A parameter value of 0 for HOLD_CYCLES, GAP_CYCLES or BOUNCE_CYCLES behaves as 1.
- REQ-021: Counters are sized by $clog2 of the largest parameter plus 1 and never wrap within a segment.
- REQ-022: The latched key maps to row index r and column index c through the package table:
  - r0 = {c3:A, c2:B, c1:C, c0:D}
  - r1 = {c3:1, c2:3, c1:5, c0:7}
  - r2 = {c3:2, c2:4, c1:6, c0:8}
  - r3 = {c3:9, c2:0, c1:E, c0:F}
- REQ-023: col[c] is 0 exactly when the contact is closed and row[r] is 0; all other col bits are always 1.
- REQ-024: col is combinational from row and the registered contact, with zero-cycle latency, so it follows the scanner's row changes within the same cycle.
- REQ-025: If multiple row bits are low, col depends only on row[r].
- REQ-026: key_valid asserted while key_ready is low is ignored; the request is neither queued nor latched.
- REQ-027: key_code changing after acceptance has no effect until the next acceptance.

Reset
- REQ-028: reset asynchronously forces state IDLE, contact open, col = 4'b1111, key_ready = 1, key_done = 0, all counters 0, and latched key 0.
- REQ-029: Reset asserted mid-sequence aborts the press immediately, with no key_done pulse.
- REQ-030: The first acceptance is possible on the first clk edge after reset deasserts.

Configuration
- REQ-031: Macro KEYPAD_EMU_BOUNCE_EN controls bounce emulation.
- REQ-032: With KEYPAD_EMU_BOUNCE_EN defined, BOUNCE_IN and BOUNCE_OUT behave per REQ-016 and REQ-018.
- REQ-033: Without KEYPAD_EMU_BOUNCE_EN, both bounce states and their counters are compiled out: IDLE goes to HOLD and HOLD goes to GAP, with clean contact edges.
- REQ-034: Without KEYPAD_EMU_BOUNCE_EN, BOUNCE_CYCLES and BOUNCE_TOGGLES are ignored.

Structure
- REQ-035: Package keypad_emu_pkg holds the state enum, a key-to-{row,col} mapping function implementing the REQ-022 table, and the active-low idle constant 4'b1111.
- REQ-036: Sub-module keypad_emu_contact owns the segment counter and contact register, taking start and busy handshakes from the top-level FSM.
- REQ-037: The top level owns the key latch, the FSM handshake and the combinational row/col matrix.

Verification
- REQ-038: Reset, then row=4'b1101 with no request -> col=4'b1111 and key_ready=1.
- REQ-039: HOLD_CYCLES=20, bounce off; request key 5 with row=4'b1101 -> col=4'b1101 for 20 cycles, then 4'b1111; key_done pulses GAP_CYCLES cycles later.
- REQ-040: Key A held while the row walks 1110/1101/1011/0111 -> col=4'b0111 only while row=4'b1110; otherwise 4'b1111.
- REQ-041: Bounce on, BOUNCE_CYCLES=3, BOUNCE_TOGGLES=4; key 1 with row=4'b1101 -> col[3] toggles 4 times at 3-cycle spacing into the hold, and 4 times out of it.
- REQ-042: Assert reset 5 cycles into HOLD of key F -> col=4'b1111 immediately, key_ready=1, and no key_done pulse.
- REQ-043: Present key_valid with key 2 during GAP -> the request is ignored; a re-request after key_ready rises is accepted and pressed at r2/c3.
